// File: rtl/multiplier_8bits_version8.sv
// rtl/multiplier_8bits_version8.sv - unsigned 8x8 -> 16-bit Dadda multiplier, registered output
//
// Purpose: partial-product AND array, Dadda carry-save reduction
//          (column heights 8 -> 6 -> 4 -> 3 -> 2) built from explicit half/full
//          adder cells, then a 16-bit carry-propagate add into the product register.
// Ports:
//   clk      in   1   rising-edge clock
//   rst      in   1   synchronous active-high reset (clears every register)
//   A        in   8   multiplicand, unsigned
//   B        in   8   multiplier, unsigned
//   product  out  16  A*B, registered
// Option: define MULT8_PIPE_EN to register the two reduced rows ahead of the
//         final adder (latency 2 instead of 1).

module multiplier_8bits_version8 (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] product
);

  // {carry, sum}
  function automatic logic [1:0] fa(input logic x, input logic y, input logic z);
    return {(x & y) | (x & z) | (y & z), x ^ y ^ z};
  endfunction

  function automatic logic [1:0] ha(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // cur[c] holds the bits of weight 2^c packed from bit 0, h[c] of them valid.
  logic [7:0]  cur [16];
  logic [7:0]  nxt [16];
  int          h   [16];
  int          nh  [16];
  int          d;
  int          idx;
  int          wt;
  int          c1;
  logic [7:0]  colv;
  logic [1:0]  cs;
  logic [15:0] row0;
  logic [15:0] row1;

  always_comb begin
    d    = 0;
    idx  = 0;
    wt   = 0;
    c1   = 0;
    colv = '0;
    cs   = '0;
    row0 = '0;
    row1 = '0;
    for (int c = 0; c < 16; c++) begin
      cur[c] = '0;
      nxt[c] = '0;
      h[c]   = 0;
      nh[c]  = 0;
    end

    // Partial products: pp[i][j] = A[j] & B[i] lands in column i+j.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        wt = i + j;
        cur[wt[3:0]][h[wt[3:0]][2:0]] = A[j] & B[i];
        h[wt[3:0]] += 1;
      end
    end

    // Dadda stages. In each column only as many cells are used as are needed
    // to bring (remaining bits + incoming carries) down to the stage target d;
    // a full adder is preferred when the column is at least two over target.
    for (int s = 0; s < 4; s++) begin
      d = (s == 0) ? 6 : (s == 1) ? 4 : (s == 2) ? 3 : 2;
      for (int c = 0; c < 16; c++) begin
        nxt[c] = '0;
        nh[c]  = 0;
      end
      for (int c = 0; c < 16; c++) begin
        idx = 0;
        c1  = c + 1;
        for (int k = 0; k < 8; k++) begin
          if ((h[c[3:0]] - idx) + nh[c[3:0]] > d) begin
            colv = cur[c[3:0]] >> idx;
            if (((h[c[3:0]] - idx) + nh[c[3:0]] - d >= 2) && (h[c[3:0]] - idx >= 3)) begin
              cs  = fa(colv[0], colv[1], colv[2]);
              idx = idx + 3;
            end else if (h[c[3:0]] - idx >= 2) begin
              cs  = ha(colv[0], colv[1]);
              idx = idx + 2;
            end else begin
              cs = '0;
            end
            nxt[c[3:0]][nh[c[3:0]][2:0]] = cs[0];
            nh[c[3:0]] += 1;
            // Column 15 never produces a real carry: the product fits 16 bits.
            if (c < 15) begin
              nxt[c1[3:0]][nh[c1[3:0]][2:0]] = cs[1];
              nh[c1[3:0]] += 1;
            end
          end
        end
        // Untouched bits pass straight through to the next stage.
        for (int k = 0; k < 8; k++) begin
          if (k >= idx && k < h[c[3:0]]) begin
            nxt[c[3:0]][nh[c[3:0]][2:0]] = cur[c[3:0]][k];
            nh[c[3:0]] += 1;
          end
        end
      end
      for (int c = 0; c < 16; c++) begin
        cur[c] = nxt[c];
        h[c]   = nh[c];
      end
    end

    for (int c = 0; c < 16; c++) begin
      row0[c] = cur[c][0];
      row1[c] = cur[c][1];
    end
  end

`ifdef MULT8_PIPE_EN
  logic [15:0] row0_q;
  logic [15:0] row1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      row0_q  <= '0;
      row1_q  <= '0;
      product <= '0;
    end else begin
      row0_q  <= row0;
      row1_q  <= row1;
      product <= row0_q + row1_q;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
    end else begin
      product <= row0 + row1;
    end
  end
`endif

endmodule

// File: tb/tb_multiplier_8bits_version8.sv
// tb/tb_multiplier_8bits_version8.sv - self-checking bench for multiplier_8bits_version8

module tb_multiplier_8bits_version8;

`ifdef MULT8_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  A   = 8'd0;
  logic [7:0]  B   = 8'd0;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  // Expected value held in each latency slot; the last slot is the output.
  logic [15:0] pipe [LAT];

  multiplier_8bits_version8 dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .B       (B),
    .product (product)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Apply one operand pair (and reset level) for one edge, then check the output.
  task automatic step(input string tag, input logic r, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst = r;
    A   = a;
    B   = b;
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < LAT; k++) pipe[k] = 16'd0;
    end else begin
      for (int k = LAT - 1; k > 0; k--) pipe[k] = pipe[k - 1];
      pipe[0] = {8'd0, a} * {8'd0, b};
    end
    #1;
    check(tag, product, pipe[LAT - 1]);
  endtask

  initial begin
    for (int k = 0; k < LAT; k++) pipe[k] = 16'd0;

    // Reset held with full-scale operands, then release.
    step("reset0", 1'b1, 8'hFF, 8'hFF);
    step("reset1", 1'b1, 8'hFF, 8'hFF);
    for (int k = 0; k < LAT; k++) step("rst_release", 1'b0, 8'hFF, 8'hFF);
    // Mid-operand glitch between edges must not matter.
    @(negedge clk);
    A = 8'h13;
    B = 8'h57;
    #1;
    check("hold_between_edges", product, pipe[LAT - 1]);

    // Zero cases.
    step("zero_zero", 1'b0, 8'd0, 8'd0);
    step("zero_200", 1'b0, 8'd0, 8'd200);

    // Directed back-to-back stream.
    step("dir_98x115", 1'b0, 8'd98, 8'd115);
    step("dir_170x99", 1'b0, 8'd170, 8'd99);
    step("dir_229x42", 1'b0, 8'd229, 8'd42);

    // Corners.
    step("c_255x1", 1'b0, 8'd255, 8'd1);
    step("c_1x255", 1'b0, 8'd1, 8'd255);
    step("c_128x128", 1'b0, 8'd128, 8'd128);
    step("c_255x255", 1'b0, 8'd255, 8'd255);
    for (int k = 1; k < LAT; k++) step("drain", 1'b0, 8'd0, 8'd0);

    // Random stream with occasional single-edge reset.
    for (int n = 0; n < 2000; n++) begin
      step(((n % 97) == 50) ? "rand_rst" : "rand", ((n % 97) == 50),
           8'($urandom), 8'($urandom));
    end

    // Exhaustive sweep.
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 256; b++) begin
        step("exhaustive", 1'b0, a[7:0], b[7:0]);
      end
    end
    for (int k = 1; k < LAT; k++) step("drain_end", 1'b0, 8'd0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
